// File: rtl/uctl_cmd_if_pkg.sv
// uctl_cmd_if_pkg: shared states and constants for the cmdIf target
package uctl_cmd_if_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD_ACK, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RD_ACK} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam logic [31:0] OOW_RDATA = 32'h0;
endpackage

// File: rtl/uctl_cmd_if_target.sv
// uctl_cmd_if_target: cmdIf responder serving write/read beats through a word-addressed memory port
module uctl_cmd_if_target
  import uctl_cmd_if_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic              hClk,
  input  logic              hReset_n,
  input  logic              swRst,
  input  logic              cmdIf_trEn,
  input  logic              cmdIf_req,
  input  logic [31:0]       cmdIf_addr,
  input  logic              cmdIf_wrRd,
  output logic              cmdIf_ack,
  input  logic              cmdIf_wrData_req,
  input  logic [31:0]       cmdIf_wrData,
  output logic              cmdIf_wrData_ack,
  input  logic              cmdIf_rdData_req,
  output logic [31:0]       cmdIf_rdData,
  output logic              cmdIf_rdData_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              addr_err
);
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
  state_t      r_state, w_nxt;
  logic [29:0] r_cnt;
  logic [2:0]  r_lat;
  logic [31:0] r_rdata;
  logic        r_wr, r_rdack, r_rderr;
  logic        w_oow, w_start, w_wr_beat, w_rd_issue, w_rd_done, w_unused;
  assign w_unused   = ^cmdIf_addr[1:0];
  assign w_oow      = r_cnt[29:ADDR_W] != BASE_ADDR[31:ADDR_W+2];
  assign w_start    = r_state == S_IDLE && cmdIf_trEn && cmdIf_req;
  assign w_wr_beat  = r_state == S_WR && cmdIf_trEn && cmdIf_wrData_req && mem_ready;
  // the registered ack cycle still sees the old req level, so no issue then
  assign w_rd_issue = r_state == S_RD_ISSUE && cmdIf_trEn && cmdIf_rdData_req && mem_ready && !r_rdack;
  assign w_rd_done  = r_state == S_RD_ACK && cmdIf_trEn;
  assign cmdIf_ack        = r_state == S_CMD_ACK && cmdIf_trEn;
  assign cmdIf_wrData_ack = w_wr_beat;
  assign cmdIf_rdData_ack = r_rdack;
  assign cmdIf_rdData     = r_rdata;
  assign mem_en    = (w_wr_beat || w_rd_issue) && !w_oow;
  assign mem_wr    = w_wr_beat && !w_oow;
  assign mem_addr  = r_cnt[ADDR_W-1:0];
  assign mem_wdata = r_state == S_WR ? cmdIf_wrData : '0;
  assign addr_err  = r_rderr || (w_wr_beat && w_oow);
  always_comb begin
    w_nxt = r_state;
    if (!cmdIf_trEn) w_nxt = S_IDLE;
    else
      case (r_state)
        S_IDLE:     w_nxt = cmdIf_req ? S_CMD_ACK : S_IDLE;
        S_CMD_ACK:  w_nxt = r_wr ? S_WR : S_RD_ISSUE;
        S_RD_ISSUE: w_nxt = w_rd_issue ? (RD_LAT == 1 ? S_RD_ACK : S_RD_WAIT) : S_RD_ISSUE;
        S_RD_WAIT:  w_nxt = r_lat == 3'd1 ? S_RD_ACK : S_RD_WAIT;
        S_RD_ACK:   w_nxt = S_RD_ISSUE;
        default:    w_nxt = r_state;
      endcase
  end
  always_ff @(posedge hClk or negedge hReset_n)
    if (!hReset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_rdack <= 1'b0;
      r_rderr <= 1'b0;
    end else if (swRst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_rdack <= 1'b0;
      r_rderr <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rdack <= w_rd_done;
      r_rderr <= w_rd_done && w_oow;
      if (w_start) begin
        r_cnt <= cmdIf_addr[31:2];
        r_wr  <= cmdIf_wrRd;
      end else if (w_wr_beat || w_rd_done) r_cnt <= r_cnt + 30'd1;
      if (w_rd_issue) r_lat <= LAT_LOAD;
      else if (r_state == S_RD_WAIT) r_lat <= r_lat - 3'd1;
      if (w_rd_done) r_rdata <= w_oow ? OOW_RDATA : mem_rdata;
    end
endmodule

// File: tb/tb_uctl_cmd_if_target.sv
// tb_uctl_cmd_if_target: scoreboard bench for the cmdIf target with a latency-modelled memory
module tb_uctl_cmd_if_target;
  localparam int AW  = 10;
  localparam int LAT = 3;
  logic hClk = 0, hReset_n = 0, swRst = 0;
  logic trEn = 0, req = 0, wrRd = 0, wreq = 0, rreq = 0, ready = 1;
  logic [31:0] addr = 0, wdata = 0, mem_rdata;
  logic cmdIf_ack, cmdIf_wrData_ack, cmdIf_rdData_ack, mem_en, mem_wr, addr_err;
  logic [31:0] cmdIf_rdData, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem [0:1023];
  logic [31:0] pipe [0:LAT];
  logic [41:0] wq[$];
  logic [32:0] rq[$];
  logic [41:0] we;
  logic [32:0] re;
  int n_chk = 0, n_err = 0, n_wr = 0, n_rd = 0;

  uctl_cmd_if_target #(.ADDR_W(AW), .BASE_ADDR(32'h0), .RD_LAT(LAT)) dut (
    .hClk(hClk), .hReset_n(hReset_n), .swRst(swRst),
    .cmdIf_trEn(trEn), .cmdIf_req(req), .cmdIf_addr(addr), .cmdIf_wrRd(wrRd), .cmdIf_ack(cmdIf_ack),
    .cmdIf_wrData_req(wreq), .cmdIf_wrData(wdata), .cmdIf_wrData_ack(cmdIf_wrData_ack),
    .cmdIf_rdData_req(rreq), .cmdIf_rdData(cmdIf_rdData), .cmdIf_rdData_ack(cmdIf_rdData_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(ready), .addr_err(addr_err)
  );

  always #5 hClk = ~hClk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // memory model: read data appears in the cycle RD_LAT after the strobe cycle
  assign mem_rdata = pipe[LAT];
  always @(negedge hClk) begin
    if (mem_en && mem_wr && ready) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_wr) ? mem[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
  end

  always @(negedge hClk) begin
    if (hReset_n && mem_en && mem_wr && ready) begin
      n_wr++;
      check("wr_pending", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        we = wq.pop_front();
        check("wr_addr", mem_addr, we[41:32]);
        check("wr_data", mem_wdata, we[31:0]);
      end
    end
    if (hReset_n && cmdIf_rdData_ack) begin
      n_rd++;
      check("rd_pending", rq.size() > 0, 1);
      if (rq.size() > 0) begin
        re = rq.pop_front();
        check("rd_data", cmdIf_rdData, re[31:0]);
        check("rd_aerr", addr_err, re[32]);
      end
    end
  end

  task automatic tick;
    @(posedge hClk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] a, input logic w);
    tick; trEn = 1; req = 1; addr = a; wrRd = w;
    #1 check("ack_early", cmdIf_ack, 0);
    tick; req = 0;
    #1 check("cmd_ack", cmdIf_ack, 1);
  endtask

  task automatic end_tr;
    tick; trEn = 0;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [AW-1:0] ea, input logic err, input int stall);
    tick; wreq = 1; wdata = d;
    for (int i = 0; i < stall; i++) begin
      ready = 0;
      #1 check("wr_stall_ack", cmdIf_wrData_ack, 0);
      check("wr_stall_en", mem_en, 0);
      tick;
    end
    ready = 1;
    if (!err) wq.push_back({ea, d});
    #1 check("wr_ack", cmdIf_wrData_ack, 1);
    check("wr_maddr", mem_addr, ea);
    check("wr_en", mem_en, !err);
    check("wr_beat_aerr", addr_err, err);
    tick; wreq = 0;
  endtask

  task automatic rd_beat(input logic [31:0] d, input logic [AW-1:0] ea, input logic err);
    bit got = 0;
    tick; rreq = 1; rq.push_back({err, d});
    #1 check("rd_en", mem_en, !err);
    check("rd_maddr", mem_addr, ea);
    for (int i = 1; i <= 20 && !got; i++) begin
      tick;
      if (cmdIf_rdData_ack) begin
        got = 1;
        check("rd_lat", i, LAT + 1);
      end
    end
    check("rd_seen", got, 1);
    rreq = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 + i;
    for (int i = 0; i < 4; i++) mem[16+i] = 32'h100 + i;
    for (int i = 0; i <= LAT; i++) pipe[i] = 0;
    #12;
    check("rst_ctl", {cmdIf_ack, cmdIf_wrData_ack, cmdIf_rdData_ack, mem_en, mem_wr, addr_err}, 0);
    check("rst_rdata", cmdIf_rdData, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    tick; hReset_n = 1;
    // single write
    cmd(32'h0000_0010, 1);
    wr_beat(32'hA5A5_1234, 4, 0, 0);
    end_tr;
    // 4-beat read burst
    cmd(32'h0000_0040, 0);
    for (int k = 0; k < 4; k++) rd_beat(32'h100 + k, AW'(16 + k), 0);
    end_tr;
    // stalled write: one access, counter advances once
    cmd(32'h0000_0080, 1);
    n0 = n_wr;
    wr_beat(32'h1111_2222, 32, 0, 5);
    check("stall_one_wr", n_wr - n0, 1);
    wr_beat(32'h3333_4444, 33, 0, 0);
    end_tr;
    // word address crossing the top of the window
    cmd(32'h0000_0FFC, 1);
    wr_beat(32'hCAFE_0001, 1023, 0, 0);
    wr_beat(32'hCAFE_0002, 0, 1, 0);
    end_tr;
    // out-of-window read
    cmd(32'h0000_1000, 0);
    rd_beat(32'h0, 0, 1);
    end_tr;
    // abort during RD_WAIT
    cmd(32'h0000_0040, 0);
    tick; rreq = 1;
    tick;
    tick; trEn = 0; rreq = 0;
    n0 = n_rd;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("abort_no_ack", cmdIf_rdData_ack, 0);
    end
    check("abort_rd_count", n_rd, n0);
    cmd(32'h0000_0040, 0);
    rd_beat(32'h100, 16, 0);
    end_tr;
    // swRst in the middle of a write burst
    cmd(32'h0000_0020, 1);
    wr_beat(32'h7777_8888, 8, 0, 0);
    tick; swRst = 1;
    tick; swRst = 0; wreq = 1; wdata = 32'h9999_0000;
    #1 check("swrst_ctl", {cmdIf_ack, cmdIf_wrData_ack, cmdIf_rdData_ack, mem_en, mem_wr, addr_err}, 0);
    check("swrst_rdata", cmdIf_rdData, 0);
    check("swrst_maddr", mem_addr, 0);
    check("swrst_wdata", mem_wdata, 0);
    wreq = 0;
    end_tr;
    tick;
    check("mem4", mem[4], 32'hA5A5_1234);
    check("mem33", mem[33], 32'h3333_4444);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
